// File: rtl/regfile8x32_rw_pkg.sv
// Shared widths, types and constants for the 8x32 register bank and its neighbours.
package regfile8x32_rw_pkg;

  localparam int unsigned REG_ADDR_W = 3;
  localparam int unsigned REG_COUNT  = 8;
  localparam int unsigned DATA_W     = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0]     word_t;

  localparam reg_addr_t ZERO_REG = 3'd0;

endpackage

// File: rtl/regfile8x32_rw_if.sv
// Read/write bus of the register bank; master drives requests, slave returns read data.
interface regfile8x32_rw_if
  import regfile8x32_rw_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
);

  logic             rd_req;
  reg_addr_t        ra_a;
  reg_addr_t        ra_b;
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  logic             rd_valid;
  logic             we;
  reg_addr_t        wa;
  logic [WIDTH-1:0] wd;
  logic             busy;

  modport master (
    output rd_req, ra_a, ra_b, we, wa, wd,
    input  rd_a, rd_b, rd_valid, busy
  );

  modport slave (
    input  rd_req, ra_a, ra_b, we, wa, wd,
    output rd_a, rd_b, rd_valid, busy
  );

endinterface

// File: rtl/regfile8x32_rw_mux8to1.sv
// 8:1 WIDTH-bit select mux; unknown select bits yield X so bad addresses are visible in simulation.
module mux8to1
  import regfile8x32_rw_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  reg_addr_t                      sel,
  input  logic [REG_COUNT-1:0][WIDTH-1:0] d,
  output logic [WIDTH-1:0]               y
);

  always_comb begin
    case (sel)
      3'd0:    y = d[0];
      3'd1:    y = d[1];
      3'd2:    y = d[2];
      3'd3:    y = d[3];
      3'd4:    y = d[4];
      3'd5:    y = d[5];
      3'd6:    y = d[6];
      3'd7:    y = d[7];
      default: y = 'x;
    endcase
  end

endmodule

// File: rtl/regfile8x32_rw.sv
// 8-entry register bank: one write port, two registered read ports with write-through bypass.
module regfile8x32_rw
  import regfile8x32_rw_pkg::*;
#(
  parameter int unsigned     WIDTH     = DATA_W,
  parameter bit              ZERO_R0   = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input logic            clk,
  input logic            rst_n,
  regfile8x32_rw_if.slave bus
);

  logic [REG_COUNT-1:0][WIDTH-1:0] mem_q;
  logic [WIDTH-1:0] mux_a, mux_b;
  logic [WIDTH-1:0] val_a, val_b;
  logic [WIDTH-1:0] rd_a_q, rd_b_q;
  logic             rd_valid_q;
  logic             wr_en;

  assign wr_en = bus.we && !(ZERO_R0 && (bus.wa == ZERO_REG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        mem_q[i] <= RESET_VAL;
      end
    end else if (wr_en) begin
      mem_q[bus.wa] <= bus.wd;
    end
  end

  mux8to1 #(
    .WIDTH(WIDTH)
  ) u_mux_a (
    .sel(bus.ra_a),
    .d  (mem_q),
    .y  (mux_a)
  );

  mux8to1 #(
    .WIDTH(WIDTH)
  ) u_mux_b (
    .sel(bus.ra_b),
    .d  (mem_q),
    .y  (mux_b)
  );

  // Zero-entry override wins over the bypass so a dropped write never leaks through.
  always_comb begin
    val_a = mux_a;
    val_b = mux_b;
    if (bus.we && (bus.wa == bus.ra_a)) val_a = bus.wd;
    if (bus.we && (bus.wa == bus.ra_b)) val_b = bus.wd;
    if (ZERO_R0 && (bus.ra_a == ZERO_REG)) val_a = '0;
    if (ZERO_R0 && (bus.ra_b == ZERO_REG)) val_b = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a_q     <= '0;
      rd_b_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_req;
      if (bus.rd_req) begin
        rd_a_q <= val_a;
        rd_b_q <= val_b;
      end
    end
  end

  assign bus.rd_a     = rd_a_q;
  assign bus.rd_b     = rd_b_q;
  assign bus.rd_valid = rd_valid_q;
  // busy mirrors the next rd_valid, forced low while reset is held.
  assign bus.busy     = bus.rd_req & rst_n;

endmodule

// File: tb/tb_regfile8x32_rw.sv
// Scoreboard bench for regfile8x32_rw: two instances (ZERO_R0=1 and ZERO_R0=0) driven in lockstep.
module tb_regfile8x32_rw;
  import regfile8x32_rw_pkg::*;

  localparam word_t RV1 = 32'h0BAD_F00D;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile8x32_rw_if bus0 ();
  regfile8x32_rw_if bus1 ();

  regfile8x32_rw #(
    .WIDTH    (DATA_W),
    .ZERO_R0  (1'b1),
    .RESET_VAL(32'h0000_0000)
  ) u_dut0 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus0)
  );

  regfile8x32_rw #(
    .WIDTH    (DATA_W),
    .ZERO_R0  (1'b0),
    .RESET_VAL(RV1)
  ) u_dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus1)
  );

  typedef struct {
    word_t a0;
    word_t b0;
    word_t a1;
    word_t b1;
  } exp_t;

  exp_t  q[$];
  word_t m0[8];
  word_t m1[8];
  word_t last[4];
  logic  exp_v;
  int    checks = 0;
  int    failures = 0;

  task automatic check(input string name, input word_t act, input word_t req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference value of a read: zero entry, then same-cycle write, then stored contents.
  function automatic word_t ref_val(input int inst, input reg_addr_t x, input logic w,
                                    input reg_addr_t wa, input word_t wd);
    if (inst == 0 && x == 3'd0) return '0;
    if (w && wa == x) return wd;
    return (inst == 0) ? m0[x] : m1[x];
  endfunction

  task automatic set_in(input logic req, input reg_addr_t a, input reg_addr_t b, input logic w,
                        input reg_addr_t wa, input word_t wd);
    bus0.rd_req = req; bus0.ra_a = a; bus0.ra_b = b; bus0.we = w; bus0.wa = wa; bus0.wd = wd;
    bus1.rd_req = req; bus1.ra_a = a; bus1.ra_b = b; bus1.we = w; bus1.wa = wa; bus1.wd = wd;
  endtask

  task automatic drive(input logic req, input reg_addr_t a, input reg_addr_t b, input logic w,
                       input reg_addr_t wa, input word_t wd);
    exp_t e;
    set_in(req, a, b, w, wa, wd);
    if (req) begin
      e.a0 = ref_val(0, a, w, wa, wd);
      e.b0 = ref_val(0, b, w, wa, wd);
      e.a1 = ref_val(1, a, w, wa, wd);
      e.b1 = ref_val(1, b, w, wa, wd);
      q.push_back(e);
    end
    if (w) begin
      if (wa != 3'd0) m0[wa] = wd;
      m1[wa] = wd;
    end
    @(posedge clk);
    #1;
  endtask

  // Asserts reset mid-cycle, checks immediate clearing, then releases after two edges.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_rd_a0", bus0.rd_a, '0);
    check("rst_rd_b0", bus0.rd_b, '0);
    check("rst_valid0", word_t'(bus0.rd_valid), '0);
    check("rst_busy0", word_t'(bus0.busy), '0);
    check("rst_rd_a1", bus1.rd_a, '0);
    check("rst_valid1", word_t'(bus1.rd_valid), '0);
    check("rst_busy1", word_t'(bus1.busy), '0);
    q.delete();
    for (int i = 0; i < 4; i++) last[i] = '0;
    for (int i = 0; i < 8; i++) begin
      m0[i] = '0;
      m1[i] = RV1;
    end
    @(posedge clk);
    #1;
    check("rst_hold_valid0", word_t'(bus0.rd_valid), '0);
    check("rst_hold_valid1", word_t'(bus1.rd_valid), '0);
    set_in(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_v <= 1'b0;
    else        exp_v <= bus0.rd_req;
  end

  // Monitor: pops one expectation per rd_valid, otherwise checks that data holds.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      check("valid0", word_t'(bus0.rd_valid), word_t'(exp_v));
      check("valid1", word_t'(bus1.rd_valid), word_t'(exp_v));
      check("busy0", word_t'(bus0.busy), word_t'(bus0.rd_req));
      if (bus0.rd_valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("rd_a0", bus0.rd_a, e.a0);
          check("rd_b0", bus0.rd_b, e.b0);
          check("rd_a1", bus1.rd_a, e.a1);
          check("rd_b1", bus1.rd_b, e.b1);
          last[0] = e.a0; last[1] = e.b0; last[2] = e.a1; last[3] = e.b1;
        end
      end else begin
        check("hold_a0", bus0.rd_a, last[0]);
        check("hold_b0", bus0.rd_b, last[1]);
        check("hold_a1", bus1.rd_a, last[2]);
        check("hold_b1", bus1.rd_b, last[3]);
      end
    end
  end

  initial begin
    set_in(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, '0);
    @(posedge clk);
    #1;
    do_reset();

    // Every address reads its reset value.
    for (int i = 0; i < 8; i++) drive(1'b1, reg_addr_t'(i), reg_addr_t'(7 - i), 1'b0, 3'd0, '0);

    // Write then read.
    drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd3, 32'hDEAD_BEEF);
    drive(1'b1, 3'd3, 3'd3, 1'b0, 3'd0, '0);

    // Same-cycle bypass on both ports.
    drive(1'b1, 3'd5, 3'd5, 1'b1, 3'd5, 32'h1234_5678);
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, '0);

    // Entry 0: dropped in instance 0, stored in instance 1.
    drive(1'b0, 3'd0, 3'd0, 1'b1, 3'd0, 32'hFFFF_FFFF);
    drive(1'b1, 3'd0, 3'd0, 1'b0, 3'd0, '0);
    drive(1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 32'h5555_AAAA);

    // Throughput then hold.
    for (int i = 1; i < 8; i++)
      drive(1'b0, 3'd0, 3'd0, 1'b1, reg_addr_t'(i), word_t'(32'h1111_1111 * i));
    for (int i = 1; i < 5; i++) drive(1'b1, reg_addr_t'(i), reg_addr_t'(8 - i), 1'b0, 3'd0, '0);
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, '0);
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, '0);
    check("hold_44_a", bus0.rd_a, 32'h4444_4444);
    check("hold_44_b", bus0.rd_b, 32'h4444_4444);

    // Reset while a read is pending.
    set_in(1'b1, 3'd3, 3'd3, 1'b0, 3'd0, '0);
    do_reset();
    drive(1'b1, 3'd3, 3'd3, 1'b0, 3'd0, '0);
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, '0);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 2) != 0), reg_addr_t'($urandom_range(0, 7)),
            reg_addr_t'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
            reg_addr_t'($urandom_range(0, 7)), word_t'($urandom));
    end

    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, '0);
    drive(1'b0, 3'd0, 3'd0, 1'b0, 3'd0, '0);
    check("queue_empty", word_t'(q.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
